// File: rtl/gerenciador_chamadas.sv
// Call-request register and SCAN dispatcher for the car motion controller.
// Latency: a button edge sets its pending bit and updates direcao 1 clock later; alvo and parar_aqui are combinational.
// Backpressure: none; each request stays latched until an atendido at its floor, a reset or a loss of power.
module gerenciador_chamadas #(
   parameter int N_ANDARES = 5,
   parameter int W_ANDAR   = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [N_ANDARES-1:0] bi,
   input  logic [N_ANDARES-2:0] be_up,
   input  logic [N_ANDARES-2:0] be_down,
   input  logic [W_ANDAR-1:0]   andar_atual,
   input  logic                 andar_valido,
   input  logic                 atendido,
   input  logic                 non_stop,
   input  logic                 potencia,
   output logic [N_ANDARES-1:0] pend_int,
   output logic [N_ANDARES-2:0] pend_up,
   output logic [N_ANDARES-2:0] pend_down,
   output logic [1:0]           direcao,
   output logic [W_ANDAR-1:0]   alvo,
   output logic                 alvo_valido,
   output logic                 parar_aqui
);
   typedef enum logic [1:0] {PARADO = 2'b00, SUBINDO = 2'b01, DESCENDO = 2'b10} dir_t;

   localparam logic [W_ANDAR-1:0] ANDAR_MIN = W_ANDAR'(1);
   localparam logic [W_ANDAR-1:0] ANDAR_MAX = W_ANDAR'(N_ANDARES);

   logic [N_ANDARES-1:0] pend_int_q, pend_int_d, bi_prev_q, bi_prev_d;
   logic [N_ANDARES-2:0] pend_up_q, pend_up_d, pend_down_q, pend_down_d;
   logic [N_ANDARES-2:0] up_prev_q, up_prev_d, down_prev_q, down_prev_d;
   logic                 armed_q, armed_d, reopen_q, reopen_d;
   dir_t                 dir_q, dir_d;

   // Floor-indexed helper vectors: bit f-1 stands for floor f.
   logic                 fl_rng, av, here_idle, clr_en;
   logic [N_ANDARES-1:0] cur_oh, above_m, below_m;
   logic [N_ANDARES-1:0] up_m, dn_m, req_m, req_m_d;
   logic                 acima, abaixo, acima_d, abaixo_d;
   logic [N_ANDARES-1:0] e_int;
   logic [N_ANDARES-2:0] e_up, e_dn, clr_up, clr_dn;

   // Decode the current floor; out-of-range numbers never count as aligned.
   always_comb begin
      cur_oh  = '0;
      above_m = '0;
      below_m = '0;
      fl_rng  = (andar_atual >= ANDAR_MIN) && (andar_atual <= ANDAR_MAX);
      av      = andar_valido && fl_rng;
      for (int i = 0; i < N_ANDARES; i++) begin
         cur_oh[i]  = fl_rng && (andar_atual == W_ANDAR'(i + 1));
         above_m[i] = W_ANDAR'(i + 1) > andar_atual;
         below_m[i] = W_ANDAR'(i + 1) < andar_atual;
      end
   end

   // Registered request view; landing calls drop out of it in non-stop mode.
   always_comb begin
      up_m   = non_stop ? '0 : {1'b0, pend_up_q};
      dn_m   = non_stop ? '0 : {pend_down_q, 1'b0};
      req_m  = pend_int_q | up_m | dn_m;
      acima  = |(req_m & above_m);
      abaixo = |(req_m & below_m);
   end

   // Edge capture, reopen detection and atendido clearing of the pending bits.
   always_comb begin
      e_int = bi & ~bi_prev_q;
      e_up  = be_up & ~up_prev_q;
      e_dn  = be_down & ~down_prev_q;
      // The first clock after reset only primes the edge registers, so a
      // button held through reset does not fire.
      if (!(armed_q && potencia)) begin
         e_int = '0;
         e_up  = '0;
         e_dn  = '0;
      end
      here_idle = av && (dir_q == PARADO);
      reopen_d  = here_idle && |(e_int & cur_oh);
      e_int     = e_int & ~(here_idle ? cur_oh : '0);

      clr_en = atendido && av;
      clr_up = '0;
      clr_dn = '0;
      if (clr_en) begin
         case (dir_q)
            SUBINDO: begin
               clr_up = cur_oh[N_ANDARES-2:0];
               clr_dn = acima ? '0 : cur_oh[N_ANDARES-1:1];
            end
            DESCENDO: begin
               clr_up = abaixo ? '0 : cur_oh[N_ANDARES-2:0];
               clr_dn = cur_oh[N_ANDARES-1:1];
            end
            default: begin
               clr_up = cur_oh[N_ANDARES-2:0];
               clr_dn = cur_oh[N_ANDARES-1:1];
            end
         endcase
      end

      // Clear is applied after the set so a same-cycle press loses.
      pend_int_d  = (pend_int_q | e_int) & ~(clr_en ? cur_oh : '0);
      pend_up_d   = (pend_up_q | e_up) & ~clr_up;
      pend_down_d = (pend_down_q | e_dn) & ~clr_dn;
      if (!potencia) begin
         pend_int_d  = '0;
         pend_up_d   = '0;
         pend_down_d = '0;
         reopen_d    = 1'b0;
      end

      bi_prev_d   = bi;
      up_prev_d   = be_up;
      down_prev_d = be_down;
      armed_d     = 1'b1;
   end

   // SCAN direction: decided from the pending state being written this clock.
   always_comb begin
      req_m_d  = pend_int_d | (non_stop ? '0 : ({1'b0, pend_up_d} | {pend_down_d, 1'b0}));
      acima_d  = |(req_m_d & above_m);
      abaixo_d = |(req_m_d & below_m);
      dir_d    = dir_q;
      if (!potencia) begin
         dir_d = PARADO;
      end else if (av) begin
         case (dir_q)
            SUBINDO:  dir_d = acima_d  ? SUBINDO  : (abaixo_d ? DESCENDO : PARADO);
            DESCENDO: dir_d = abaixo_d ? DESCENDO : (acima_d  ? SUBINDO  : PARADO);
            default:  dir_d = acima_d  ? SUBINDO  : (abaixo_d ? DESCENDO : PARADO);
         endcase
      end
   end

   // Target floor and stop request toward the controller.
   always_comb begin
      alvo = '0;
      case (dir_q)
         SUBINDO: begin
            for (int i = N_ANDARES - 1; i >= 0; i--)
               if (req_m[i] && above_m[i]) alvo = W_ANDAR'(i + 1);
         end
         DESCENDO: begin
            for (int i = 0; i < N_ANDARES; i++)
               if (req_m[i] && below_m[i]) alvo = W_ANDAR'(i + 1);
         end
         default: begin
            if (|(req_m & cur_oh)) alvo = andar_atual;
         end
      endcase
      if (!potencia) alvo = '0;
      alvo_valido = (alvo != '0);

      parar_aqui = av && potencia && (
            reopen_q
         || |(pend_int_q & cur_oh)
         || ((dir_q == SUBINDO)  && |(up_m & cur_oh))
         || ((dir_q == DESCENDO) && |(dn_m & cur_oh))
         || ((dir_q == SUBINDO)  && !acima  && |(dn_m & cur_oh))
         || ((dir_q == DESCENDO) && !abaixo && |(up_m & cur_oh))
         || ((dir_q == PARADO)   && |(req_m & cur_oh)));
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         pend_int_q  <= '0;
         pend_up_q   <= '0;
         pend_down_q <= '0;
         bi_prev_q   <= '0;
         up_prev_q   <= '0;
         down_prev_q <= '0;
         armed_q     <= 1'b0;
         reopen_q    <= 1'b0;
         dir_q       <= PARADO;
      end else begin
         pend_int_q  <= pend_int_d;
         pend_up_q   <= pend_up_d;
         pend_down_q <= pend_down_d;
         bi_prev_q   <= bi_prev_d;
         up_prev_q   <= up_prev_d;
         down_prev_q <= down_prev_d;
         armed_q     <= armed_d;
         reopen_q    <= reopen_d;
         dir_q       <= dir_d;
      end
   end

   assign pend_int  = pend_int_q;
   assign pend_up   = pend_up_q;
   assign pend_down = pend_down_q;
   assign direcao   = dir_q;
endmodule

// File: tb/tb_gerenciador_chamadas.sv
// Self-checking bench for the call-request dispatcher.
// Latency: one stimulus row per clock, outputs sampled 1 ns after the rising edge.
// Backpressure: not applicable; expected snapshots are queued as rows are driven.
module tb_gerenciador_chamadas;
   logic       clock = 1'b0;
   logic       reset;
   logic [4:0] bi;
   logic [3:0] be_up, be_down;
   logic [2:0] andar_atual;
   logic       andar_valido, atendido, non_stop, potencia;
   logic [4:0] pend_int;
   logic [3:0] pend_up, pend_down;
   logic [1:0] direcao;
   logic [2:0] alvo;
   logic       alvo_valido, parar_aqui;

   gerenciador_chamadas #(.N_ANDARES(5), .W_ANDAR(3)) dut (
      .clock(clock), .reset(reset), .bi(bi), .be_up(be_up), .be_down(be_down),
      .andar_atual(andar_atual), .andar_valido(andar_valido), .atendido(atendido),
      .non_stop(non_stop), .potencia(potencia), .pend_int(pend_int), .pend_up(pend_up),
      .pend_down(pend_down), .direcao(direcao), .alvo(alvo), .alvo_valido(alvo_valido),
      .parar_aqui(parar_aqui)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [4:0] bi;
      logic [3:0] up;
      logic [3:0] dn;
      logic [2:0] fl;
      logic       vld;
      logic       at;
      logic       ns;
      logic       pw;
      logic       rst;
   } stim_t;

   // {pend_int, pend_up, pend_down, direcao, alvo, alvo_valido, parar_aqui}
   typedef logic [19:0] exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   exp_t obs;

   assign obs = {pend_int, pend_up, pend_down, direcao, alvo, alvo_valido, parar_aqui};

   function automatic stim_t S(input logic [4:0] b, input logic [3:0] u, input logic [3:0] d,
                               input logic [2:0] f, input logic v, input logic a,
                               input logic n, input logic p, input logic r);
      stim_t s;
      s = {b, u, d, f, v, a, n, p, r};
      return s;
   endfunction

   function automatic exp_t E(input logic [4:0] pi, input logic [3:0] pu, input logic [3:0] pd,
                              input logic [1:0] dr, input logic [2:0] al, input logic pa);
      exp_t e;
      e = {pi, pu, pd, dr, al, (al != 3'd0), pa};
      return e;
   endfunction

   task automatic apply(input stim_t s);
      @(negedge clock);
      bi = s.bi; be_up = s.up; be_down = s.dn; andar_atual = s.fl;
      andar_valido = s.vld; atendido = s.at; non_stop = s.ns; potencia = s.pw; reset = s.rst;
   endtask

   task automatic test_reset;
      stim_t st[$]; exp_t ex[$]; exp_t e;
      for (int k = 0; k < 3; k++) begin
         st.push_back(S(5'b11111, 4'b0, 4'b0, 3'd1, 1, 0, 0, 1, 1)); ex.push_back(E(0, 0, 0, 2'b00, 0, 0));
      end
      st.push_back(S(5'b11111, 4'b0, 4'b0, 3'd1, 1, 0, 0, 1, 0)); ex.push_back(E(0, 0, 0, 2'b00, 0, 0));
      st.push_back(S(5'b11111, 4'b0, 4'b0, 3'd1, 1, 0, 0, 1, 0)); ex.push_back(E(0, 0, 0, 2'b00, 0, 0));
      st.push_back(S(5'b00000, 4'b0, 4'b0, 3'd1, 1, 0, 0, 1, 0)); ex.push_back(E(0, 0, 0, 2'b00, 0, 0));
      foreach (st[i]) begin
         apply(st[i]); exp_q.push_back(ex[i]);
         @(posedge clock); #1;
         e = exp_q.pop_front(); vectors++;
         if (obs !== e) begin
            miscompares++;
            $display("FAIL reset row %0d: got %b required %b", i, obs, e);
         end
      end
   endtask

   task automatic test_landing_here;
      stim_t st[$]; exp_t ex[$]; exp_t e;
      st.push_back(S(0, 4'b0001, 0, 3'd1, 1, 0, 0, 1, 0)); ex.push_back(E(0, 4'b0001, 0, 2'b00, 1, 1));
      st.push_back(S(0, 4'b0001, 0, 3'd1, 1, 0, 0, 1, 0)); ex.push_back(E(0, 4'b0001, 0, 2'b00, 1, 1));
      st.push_back(S(0, 4'b0001, 0, 3'd1, 1, 1, 0, 1, 0)); ex.push_back(E(0, 0, 0, 2'b00, 0, 0));
      st.push_back(S(0, 4'b0001, 0, 3'd1, 1, 0, 0, 1, 0)); ex.push_back(E(0, 0, 0, 2'b00, 0, 0));
      st.push_back(S(0, 4'b0000, 0, 3'd1, 1, 0, 0, 1, 0)); ex.push_back(E(0, 0, 0, 2'b00, 0, 0));
      foreach (st[i]) begin
         apply(st[i]); exp_q.push_back(ex[i]);
         @(posedge clock); #1;
         e = exp_q.pop_front(); vectors++;
         if (obs !== e) begin
            miscompares++;
            $display("FAIL landing_here row %0d: got %b required %b", i, obs, e);
         end
      end
   endtask

   task automatic test_cab_up;
      stim_t st[$]; exp_t ex[$]; exp_t e;
      st.push_back(S(5'b10000, 0, 0, 3'd1, 1, 0, 0, 1, 0)); ex.push_back(E(5'b10000, 0, 0, 2'b01, 5, 0));
      st.push_back(S(5'b00000, 0, 0, 3'd0, 1, 0, 0, 1, 0)); ex.push_back(E(5'b10000, 0, 0, 2'b01, 5, 0));
      st.push_back(S(5'b00000, 0, 0, 3'd3, 0, 0, 0, 1, 0)); ex.push_back(E(5'b10000, 0, 0, 2'b01, 5, 0));
      st.push_back(S(5'b00000, 0, 0, 3'd5, 1, 0, 0, 1, 0)); ex.push_back(E(5'b10000, 0, 0, 2'b00, 5, 1));
      st.push_back(S(5'b00000, 0, 0, 3'd5, 1, 1, 0, 1, 0)); ex.push_back(E(0, 0, 0, 2'b00, 0, 0));
      foreach (st[i]) begin
         apply(st[i]); exp_q.push_back(ex[i]);
         @(posedge clock); #1;
         e = exp_q.pop_front(); vectors++;
         if (obs !== e) begin
            miscompares++;
            $display("FAIL cab_up row %0d: got %b required %b", i, obs, e);
         end
      end
   endtask

   task automatic test_down_scan;
      stim_t st[$]; exp_t ex[$]; exp_t e;
      st.push_back(S(0, 0, 4'b1000, 3'd5, 1, 0, 0, 1, 0));       ex.push_back(E(0, 0, 4'b1000, 2'b00, 5, 1));
      st.push_back(S(0, 0, 4'b0000, 3'd5, 1, 1, 0, 1, 0));       ex.push_back(E(0, 0, 0, 2'b00, 0, 0));
      st.push_back(S(5'b00101, 4'b0010, 0, 3'd5, 1, 0, 0, 1, 0)); ex.push_back(E(5'b00101, 4'b0010, 0, 2'b10, 3, 0));
      st.push_back(S(0, 0, 0, 3'd4, 1, 0, 0, 1, 0));             ex.push_back(E(5'b00101, 4'b0010, 0, 2'b10, 3, 0));
      st.push_back(S(0, 0, 0, 3'd3, 1, 0, 0, 1, 0));             ex.push_back(E(5'b00101, 4'b0010, 0, 2'b10, 2, 1));
      st.push_back(S(0, 0, 0, 3'd3, 1, 1, 0, 1, 0));             ex.push_back(E(5'b00001, 4'b0010, 0, 2'b10, 2, 0));
      st.push_back(S(0, 0, 0, 3'd2, 1, 0, 0, 1, 0));             ex.push_back(E(5'b00001, 4'b0010, 0, 2'b10, 1, 0));
      st.push_back(S(0, 0, 0, 3'd1, 1, 0, 0, 1, 0));             ex.push_back(E(5'b00001, 4'b0010, 0, 2'b01, 2, 1));
      st.push_back(S(0, 0, 0, 3'd1, 1, 1, 0, 1, 0));             ex.push_back(E(0, 4'b0010, 0, 2'b01, 2, 0));
      st.push_back(S(0, 0, 0, 3'd2, 1, 0, 0, 1, 0));             ex.push_back(E(0, 4'b0010, 0, 2'b00, 2, 1));
      st.push_back(S(0, 0, 0, 3'd2, 1, 1, 0, 1, 0));             ex.push_back(E(0, 0, 0, 2'b00, 0, 0));
      foreach (st[i]) begin
         apply(st[i]); exp_q.push_back(ex[i]);
         @(posedge clock); #1;
         e = exp_q.pop_front(); vectors++;
         if (obs !== e) begin
            miscompares++;
            $display("FAIL down_scan row %0d: got %b required %b", i, obs, e);
         end
      end
   endtask

   task automatic test_non_stop;
      stim_t st[$]; exp_t ex[$]; exp_t e;
      st.push_back(S(0, 0, 0, 3'd1, 1, 0, 1, 1, 0));             ex.push_back(E(0, 0, 0, 2'b00, 0, 0));
      st.push_back(S(0, 4'b0010, 0, 3'd1, 1, 0, 1, 1, 0));       ex.push_back(E(0, 4'b0010, 0, 2'b00, 0, 0));
      st.push_back(S(5'b01100, 0, 0, 3'd1, 1, 0, 1, 1, 0));      ex.push_back(E(5'b01100, 4'b0010, 0, 2'b01, 3, 0));
      st.push_back(S(0, 0, 0, 3'd2, 1, 0, 1, 1, 0));             ex.push_back(E(5'b01100, 4'b0010, 0, 2'b01, 3, 0));
      st.push_back(S(0, 0, 0, 3'd3, 1, 0, 1, 1, 0));             ex.push_back(E(5'b01100, 4'b0010, 0, 2'b01, 4, 1));
      st.push_back(S(0, 0, 0, 3'd3, 1, 1, 1, 1, 0));             ex.push_back(E(5'b01000, 4'b0010, 0, 2'b01, 4, 0));
      st.push_back(S(0, 0, 0, 3'd4, 1, 0, 1, 1, 0));             ex.push_back(E(5'b01000, 4'b0010, 0, 2'b00, 4, 1));
      st.push_back(S(0, 0, 0, 3'd4, 1, 1, 1, 1, 0));             ex.push_back(E(0, 4'b0010, 0, 2'b00, 0, 0));
      st.push_back(S(5'b01000, 0, 0, 3'd4, 1, 0, 1, 1, 0));      ex.push_back(E(0, 4'b0010, 0, 2'b00, 0, 1));
      st.push_back(S(5'b01000, 0, 0, 3'd4, 1, 0, 1, 1, 0));      ex.push_back(E(0, 4'b0010, 0, 2'b00, 0, 0));
      st.push_back(S(0, 0, 0, 3'd4, 1, 0, 0, 1, 0));             ex.push_back(E(0, 4'b0010, 0, 2'b10, 2, 0));
      foreach (st[i]) begin
         apply(st[i]); exp_q.push_back(ex[i]);
         @(posedge clock); #1;
         e = exp_q.pop_front(); vectors++;
         if (obs !== e) begin
            miscompares++;
            $display("FAIL non_stop row %0d: got %b required %b", i, obs, e);
         end
      end
   endtask

   task automatic test_power;
      stim_t st[$]; exp_t ex[$]; exp_t e;
      st.push_back(S(5'b10000, 0, 4'b0001, 3'd4, 1, 0, 0, 1, 0)); ex.push_back(E(5'b10000, 4'b0010, 4'b0001, 2'b10, 2, 0));
      st.push_back(S(5'b10000, 0, 4'b0001, 3'd4, 1, 0, 0, 0, 0)); ex.push_back(E(0, 0, 0, 2'b00, 0, 0));
      st.push_back(S(5'b10001, 0, 4'b0001, 3'd4, 1, 0, 0, 0, 0)); ex.push_back(E(0, 0, 0, 2'b00, 0, 0));
      st.push_back(S(5'b10001, 0, 4'b0001, 3'd4, 1, 0, 0, 1, 0)); ex.push_back(E(0, 0, 0, 2'b00, 0, 0));
      st.push_back(S(5'b00000, 0, 4'b0000, 3'd4, 1, 0, 0, 1, 0)); ex.push_back(E(0, 0, 0, 2'b00, 0, 0));
      foreach (st[i]) begin
         apply(st[i]); exp_q.push_back(ex[i]);
         @(posedge clock); #1;
         e = exp_q.pop_front(); vectors++;
         if (obs !== e) begin
            miscompares++;
            $display("FAIL power row %0d: got %b required %b", i, obs, e);
         end
      end
   endtask

   task automatic test_back_to_back;
      stim_t st[$]; exp_t ex[$]; exp_t e;
      st.push_back(S(5'b00011, 4'b0100, 0, 3'd4, 1, 0, 0, 1, 0)); ex.push_back(E(5'b00011, 4'b0100, 0, 2'b10, 3, 0));
      st.push_back(S(5'b00000, 4'b0000, 0, 3'd4, 1, 0, 0, 1, 1)); ex.push_back(E(0, 0, 0, 2'b00, 0, 0));
      st.push_back(S(5'b00000, 4'b0000, 0, 3'd4, 1, 0, 0, 1, 0)); ex.push_back(E(0, 0, 0, 2'b00, 0, 0));
      st.push_back(S(5'b00001, 4'b0000, 0, 3'd4, 1, 0, 0, 1, 0)); ex.push_back(E(5'b00001, 0, 0, 2'b10, 1, 0));
      st.push_back(S(5'b00000, 4'b0000, 0, 3'd4, 1, 0, 0, 1, 0)); ex.push_back(E(5'b00001, 0, 0, 2'b10, 1, 0));
      st.push_back(S(5'b00001, 4'b0000, 0, 3'd4, 1, 0, 0, 1, 0)); ex.push_back(E(5'b00001, 0, 0, 2'b10, 1, 0));
      foreach (st[i]) begin
         apply(st[i]); exp_q.push_back(ex[i]);
         @(posedge clock); #1;
         e = exp_q.pop_front(); vectors++;
         if (obs !== e) begin
            miscompares++;
            $display("FAIL back_to_back row %0d: got %b required %b", i, obs, e);
         end
      end
   endtask

   initial begin
      reset = 1'b1; bi = '0; be_up = '0; be_down = '0; andar_atual = 3'd1;
      andar_valido = 1'b1; atendido = 1'b0; non_stop = 1'b0; potencia = 1'b1;
      test_reset();
      test_landing_here();
      test_cab_up();
      test_down_scan();
      test_non_stop();
      test_power();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
